// File: rtl/nastilite_regfile.sv
// ============================================================================
// nastilite_regfile : parametrised NASTILite slave configuration/status regs
// Revision 1.0
// ============================================================================
`default_nettype none

module nastilite_regfile #(
  parameter int                             ADDR_WIDTH  = 8,
  parameter int                             DATA_WIDTH  = 64,
  parameter int                             NUM_REGS    = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           s_nastilite_clk,
  input  logic                           s_nastilite_areset,
  input  logic                           s_nastilite_aw_valid,
  output logic                           s_nastilite_aw_ready,
  input  logic [ADDR_WIDTH-1:0]          s_nastilite_aw_addr,
  input  logic                           s_nastilite_w_valid,
  output logic                           s_nastilite_w_ready,
  input  logic [DATA_WIDTH-1:0]          s_nastilite_w_data,
  input  logic [DATA_WIDTH/8-1:0]        s_nastilite_w_strb,
  output logic                           s_nastilite_b_valid,
  input  logic                           s_nastilite_b_ready,
  output logic [1:0]                     s_nastilite_b_resp,
  input  logic                           s_nastilite_ar_valid,
  output logic                           s_nastilite_ar_ready,
  input  logic [ADDR_WIDTH-1:0]          s_nastilite_ar_addr,
  output logic                           s_nastilite_r_valid,
  input  logic                           s_nastilite_r_ready,
  output logic [DATA_WIDTH-1:0]          s_nastilite_r_data,
  output logic [1:0]                     s_nastilite_r_resp,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int C_STRB_W = DATA_WIDTH / 8;
  localparam int C_LSB    = $clog2(C_STRB_W);
  localparam int C_IDX_W  = ADDR_WIDTH - C_LSB;

  logic                           aw_full_q;
  logic [C_IDX_W-1:0]             aw_idx_q;
  logic                           w_full_q;
  logic [DATA_WIDTH-1:0]          w_data_q;
  logic [C_STRB_W-1:0]            w_strb_q;
  logic                           b_valid_q;
  logic [1:0]                     b_resp_q;
  logic [1:0]                     b_resp_d;
  logic                           r_valid_q;
  logic [DATA_WIDTH-1:0]          r_data_q;
  logic [DATA_WIDTH-1:0]          r_data_d;
  logic [1:0]                     r_resp_q;
  logic [1:0]                     r_resp_d;
  logic [NUM_REGS-1:0]            wr_pulse_q;
  logic [NUM_REGS-1:0]            wr_pulse_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] cfg_q;

  logic [C_IDX_W-1:0] ar_idx;
  logic               commit;
  logic               aw_hit;
  logic               ar_ready_int;
  logic               ar_hs;
  logic               unused_bits;

  assign ar_idx       = s_nastilite_ar_addr[ADDR_WIDTH-1:C_LSB];
  assign commit       = aw_full_q & w_full_q & (~b_valid_q | s_nastilite_b_ready);
  assign ar_ready_int = ~r_valid_q | s_nastilite_r_ready;
  assign ar_hs        = s_nastilite_ar_valid & ar_ready_int;

  // Byte-offset address bits and the status of writable registers are never consulted.
  assign unused_bits = ^{s_nastilite_aw_addr[C_LSB-1:0], s_nastilite_ar_addr[C_LSB-1:0], status_in};

  always_comb begin
    wr_pulse_d = '0;
    aw_hit     = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (aw_idx_q == C_IDX_W'(k)) begin
        aw_hit        = 1'b1;
        wr_pulse_d[k] = commit & ~RO_MASK[k];
      end
    end
    b_resp_d = aw_hit ? 2'b00 : 2'b10;
  end

  always_comb begin
    r_data_d = '0;
    r_resp_d = 2'b10;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == C_IDX_W'(k)) begin
        r_resp_d = 2'b00;
        r_data_d = RO_MASK[k] ? status_in[k*DATA_WIDTH +: DATA_WIDTH]
                              : cfg_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read-only slots keep their reset value since their write enable is never raised.
  always_ff @(posedge s_nastilite_clk or posedge s_nastilite_areset) begin
    if (s_nastilite_areset) begin
      cfg_q <= RESET_VALUE;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        for (int b = 0; b < C_STRB_W; b++) begin
          if (wr_pulse_d[k] && w_strb_q[b]) begin
            cfg_q[k*DATA_WIDTH + b*8 +: 8] <= w_data_q[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge s_nastilite_clk or posedge s_nastilite_areset) begin
    if (s_nastilite_areset) begin
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= 2'b00;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= 2'b00;
      wr_pulse_q <= '0;
    end else begin
      if (commit) begin
        aw_full_q <= 1'b0;
      end else if (s_nastilite_aw_valid && !aw_full_q) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s_nastilite_aw_addr[ADDR_WIDTH-1:C_LSB];
      end

      if (commit) begin
        w_full_q <= 1'b0;
      end else if (s_nastilite_w_valid && !w_full_q) begin
        w_full_q <= 1'b1;
        w_data_q <= s_nastilite_w_data;
        w_strb_q <= s_nastilite_w_strb;
      end

      if (commit) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= b_resp_d;
      end else if (s_nastilite_b_ready) begin
        b_valid_q <= 1'b0;
      end

      if (ar_hs) begin
        r_valid_q <= 1'b1;
        r_data_q  <= r_data_d;
        r_resp_q  <= r_resp_d;
      end else if (s_nastilite_r_ready) begin
        r_valid_q <= 1'b0;
      end

      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign s_nastilite_aw_ready = ~aw_full_q & ~s_nastilite_areset;
  assign s_nastilite_w_ready  = ~w_full_q & ~s_nastilite_areset;
  assign s_nastilite_ar_ready = ar_ready_int & ~s_nastilite_areset;
  assign s_nastilite_b_valid  = b_valid_q;
  assign s_nastilite_b_resp   = b_resp_q;
  assign s_nastilite_r_valid  = r_valid_q;
  assign s_nastilite_r_data   = r_data_q;
  assign s_nastilite_r_resp   = r_resp_q;
  assign cfg_regs             = cfg_q;
  assign wr_pulse             = wr_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_nastilite_regfile.sv
// ============================================================================
// tb_nastilite_regfile : directed bench with a queue-based transaction model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_nastilite_regfile;

  localparam logic [255:0] RV  = {64'h0, 64'h5A, 64'h0, 64'h0};
  localparam logic [3:0]   ROM = 4'b1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         aw_valid = 1'b0, aw_ready;
  logic [7:0]   aw_addr = '0;
  logic         w_valid = 1'b0, w_ready;
  logic [63:0]  w_data = '0;
  logic [7:0]   w_strb = '0;
  logic         b_valid, b_ready = 1'b1;
  logic [1:0]   b_resp;
  logic         ar_valid = 1'b0, ar_ready;
  logic [7:0]   ar_addr = '0;
  logic         r_valid, r_ready = 1'b1;
  logic [63:0]  r_data;
  logic [1:0]   r_resp;
  logic [255:0] status_in = {64'hABCD, 64'h3333, 64'h2222, 64'h1111};
  logic [255:0] cfg_regs;
  logic [3:0]   wr_pulse;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pulse4 = 0;

  nastilite_regfile #(
    .ADDR_WIDTH(8), .DATA_WIDTH(64), .NUM_REGS(4), .RO_MASK(ROM), .RESET_VALUE(RV)
  ) dut (
    .s_nastilite_clk(clk),           .s_nastilite_areset(rst),
    .s_nastilite_aw_valid(aw_valid), .s_nastilite_aw_ready(aw_ready),
    .s_nastilite_aw_addr(aw_addr),
    .s_nastilite_w_valid(w_valid),   .s_nastilite_w_ready(w_ready),
    .s_nastilite_w_data(w_data),     .s_nastilite_w_strb(w_strb),
    .s_nastilite_b_valid(b_valid),   .s_nastilite_b_ready(b_ready),
    .s_nastilite_b_resp(b_resp),
    .s_nastilite_ar_valid(ar_valid), .s_nastilite_ar_ready(ar_ready),
    .s_nastilite_ar_addr(ar_addr),
    .s_nastilite_r_valid(r_valid),   .s_nastilite_r_ready(r_ready),
    .s_nastilite_r_data(r_data),     .s_nastilite_r_resp(r_resp),
    .status_in(status_in),           .cfg_regs(cfg_regs),
    .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  // Transaction-level model: pending traffic lives in queues, registers in an array.
  typedef struct packed { logic [63:0] d; logic [7:0] s; } wbeat_t;
  typedef struct packed { logic [63:0] d; logic [1:0] r; } rbeat_t;
  typedef struct { logic [63:0] d; logic [1:0] r; int c; } obs_t;

  logic [63:0] m_regs [4];
  logic [7:0]  m_awq [$];
  wbeat_t      m_wq [$];
  logic [1:0]  m_bq [$];
  rbeat_t      m_rq [$];
  logic [3:0]  m_pulse;
  logic [1:0]  obs_b [$];
  obs_t        obs_r [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_awq.delete(); m_wq.delete(); m_bq.delete(); m_rq.delete();
    for (int i = 0; i < 4; i++) m_regs[i] = RV[i*64 +: 64];
    m_pulse = '0;
  endtask

  function automatic rbeat_t model_read(input logic [7:0] a);
    int idx;
    rbeat_t rb;
    idx = int'(a[7:3]);
    if (idx >= 4)      rb = '{d: 64'h0, r: 2'b10};
    else if (ROM[idx]) rb = '{d: status_in[idx*64 +: 64], r: 2'b00};
    else               rb = '{d: m_regs[idx], r: 2'b00};
    return rb;
  endfunction

  task automatic model_step();
    bit aw_rdy, w_rdy, ar_rdy, commit;
    logic [7:0] a;
    wbeat_t w;
    int idx;
    aw_rdy = (m_awq.size() == 0);
    w_rdy  = (m_wq.size() == 0);
    ar_rdy = (m_rq.size() == 0) || r_ready;
    commit = (m_awq.size() > 0) && (m_wq.size() > 0) && ((m_bq.size() == 0) || b_ready);
    m_pulse = '0;
    if (m_rq.size() > 0 && r_ready) void'(m_rq.pop_front());
    if (ar_valid && ar_rdy) m_rq.push_back(model_read(ar_addr));
    if (m_bq.size() > 0 && b_ready) void'(m_bq.pop_front());
    if (commit) begin
      a = m_awq.pop_front();
      w = m_wq.pop_front();
      idx = int'(a[7:3]);
      if (idx >= 4) m_bq.push_back(2'b10);
      else begin
        m_bq.push_back(2'b00);
        if (!ROM[idx]) begin
          for (int b = 0; b < 8; b++)
            if (w.s[b]) m_regs[idx][b*8 +: 8] = w.d[b*8 +: 8];
          m_pulse[idx] = 1'b1;
        end
      end
    end
    if (aw_valid && aw_rdy) m_awq.push_back(aw_addr);
    if (w_valid && w_rdy) m_wq.push_back('{d: w_data, s: w_strb});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  task automatic check_outputs();
    if (rst) begin
      chk("rst_aw_ready", aw_ready, 0); chk("rst_w_ready", w_ready, 0);
      chk("rst_ar_ready", ar_ready, 0); chk("rst_b_valid", b_valid, 0);
      chk("rst_b_resp", b_resp, 0);     chk("rst_r_valid", r_valid, 0);
      chk("rst_r_resp", r_resp, 0);     chk("rst_r_data", r_data, 0);
      chk("rst_wr_pulse", wr_pulse, 0);
    end else begin
      chk("aw_ready", aw_ready, m_awq.size() == 0);
      chk("w_ready", w_ready, m_wq.size() == 0);
      chk("ar_ready", ar_ready, (m_rq.size() == 0) || r_ready);
      chk("b_valid", b_valid, m_bq.size() > 0);
      if (m_bq.size() > 0) chk("b_resp", b_resp, m_bq[0]);
      chk("r_valid", r_valid, m_rq.size() > 0);
      if (m_rq.size() > 0) begin
        chk("r_data", r_data, m_rq[0].d);
        chk("r_resp", r_resp, m_rq[0].r);
      end
      chk("wr_pulse", wr_pulse, m_pulse);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("cfg_regs[%0d]", i), cfg_regs[i*64 +: 64], m_regs[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check_outputs();
      if (!rst && b_valid && b_ready) obs_b.push_back(b_resp);
      if (!rst && r_valid && r_ready) obs_r.push_back('{r_data, r_resp, cyc});
      if (wr_pulse == 4'h4) n_pulse4++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic xfer(input bit da, input bit dw, input logic [7:0] a,
                      input logic [63:0] d, input logic [7:0] s);
    bit ad, wd, ha, hw;
    int n;
    ad = !da; wd = !dw; n = 0;
    aw_valid = da; aw_addr = a; w_valid = dw; w_data = d; w_strb = s;
    while (!(ad && wd) && n < 40) begin
      @(negedge clk);
      ha = aw_valid && aw_ready;
      hw = w_valid && w_ready;
      tick();
      if (ha) begin ad = 1'b1; aw_valid = 1'b0; end
      if (hw) begin wd = 1'b1; w_valid = 1'b0; end
      n++;
    end
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("write_handshake", ad && wd, 1);
  endtask

  task automatic wait_b(input int t);
    int n = 0;
    while (obs_b.size() < t && n < 50) begin tick(); n++; end
    chk("b_beat_arrival", obs_b.size() >= t, 1);
  endtask

  task automatic wait_r(input int t);
    int n = 0;
    while (obs_r.size() < t && n < 50) begin tick(); n++; end
    chk("r_beat_arrival", obs_r.size() >= t, 1);
  endtask

  task automatic rd(input logic [7:0] a, output logic [63:0] d, output logic [1:0] r);
    int t, n;
    bit h;
    t = obs_r.size() + 1; n = 0; h = 1'b0;
    ar_valid = 1'b1; ar_addr = a;
    while (!h && n < 40) begin
      @(negedge clk);
      h = ar_valid && ar_ready;
      tick();
      n++;
    end
    ar_valid = 1'b0;
    wait_r(t);
    d = obs_r[t-1].d;
    r = obs_r[t-1].r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nr, p0;
    logic [63:0] d;
    logic [1:0] r;

    repeat (3) tick();
    chk("reset_cfg2", cfg_regs[128 +: 64], 64'h5A);
    chk("reset_aw_ready_low", aw_ready, 0);
    rst = 1'b0;
    tick();

    // Reset while a write sits fully buffered but not yet committed.
    xfer(1, 1, 8'h10, 64'h99, 8'hFF);
    wait_b(1);
    chk("pre_reset_cfg2", cfg_regs[128 +: 64], 64'h99);
    nb = obs_b.size();
    aw_valid = 1'b1; aw_addr = 8'h10; w_valid = 1'b1; w_data = 64'hBEEF; w_strb = 8'hFF;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_b_valid", b_valid, 0);
    chk("midrst_r_valid", r_valid, 0);
    chk("midrst_cfg2", cfg_regs[128 +: 64], 64'h5A);
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("no_b_after_reset", obs_b.size(), nb);
    chk("post_reset_cfg2", cfg_regs[128 +: 64], 64'h5A);

    // AW first, W three cycles later.
    nb = obs_b.size(); p0 = n_pulse4;
    xfer(1, 0, 8'h10, 64'h0, 8'h00);
    tick(); tick();
    xfer(0, 1, 8'h00, 64'h1122334455667788, 8'hFF);
    wait_b(nb + 1);
    tick(); tick();
    chk("order_b_resp", obs_b[nb], 2'b00);
    chk("order_cfg2", cfg_regs[128 +: 64], 64'h1122334455667788);
    chk("order_pulse_cycles", n_pulse4 - p0, 1);

    // Partial strobe, including the top byte lane.
    nb = obs_b.size();
    xfer(1, 1, 8'h08, 64'h0, 8'hFF);
    wait_b(nb + 1);
    xfer(1, 1, 8'h08, 64'hFFFFFFFFFFFFFFFF, 8'h81);
    wait_b(nb + 2);
    chk("partial_reg1", cfg_regs[64 +: 64], 64'hFF000000000000FF);

    // Out of range and read-only.
    nb = obs_b.size();
    xfer(1, 1, 8'h40, 64'hDEAD, 8'hFF);
    wait_b(nb + 1);
    chk("oor_b_resp", obs_b[nb], 2'b10);
    chk("oor_reg0", cfg_regs[0 +: 64], 64'h0);
    chk("oor_reg1", cfg_regs[64 +: 64], 64'hFF000000000000FF);
    chk("oor_reg2", cfg_regs[128 +: 64], 64'h1122334455667788);
    xfer(1, 1, 8'h18, 64'h1234, 8'hFF);
    wait_b(nb + 2);
    chk("ro_b_resp", obs_b[nb+1], 2'b00);
    chk("ro_reg3", cfg_regs[192 +: 64], 64'h0);
    rd(8'h18, d, r);
    chk("ro_read_data", d, 64'hABCD);
    chk("ro_read_resp", r, 2'b00);
    rd(8'h40, d, r);
    chk("oor_read_data", d, 64'h0);
    chk("oor_read_resp", r, 2'b10);

    // Write-response backpressure.
    b_ready = 1'b0;
    nb = obs_b.size();
    xfer(1, 1, 8'h00, 64'hA5A5, 8'hFF);
    xfer(1, 1, 8'h40, 64'hBAD, 8'hFF);
    repeat (3) tick();
    chk("bp_aw_ready", aw_ready, 0);
    chk("bp_w_ready", w_ready, 0);
    chk("bp_b_valid", b_valid, 1);
    chk("bp_no_beat", obs_b.size(), nb);
    b_ready = 1'b1;
    wait_b(nb + 2);
    chk("bp_first_resp", obs_b[nb], 2'b00);
    chk("bp_second_resp", obs_b[nb+1], 2'b10);
    chk("bp_reg0", cfg_regs[0 +: 64], 64'hA5A5);

    // Read on the same edge as a commit to the same register.
    nb = obs_b.size();
    xfer(1, 1, 8'h08, 64'h11, 8'hFF);
    wait_b(nb + 1);
    nr = obs_r.size();
    aw_valid = 1'b1; aw_addr = 8'h08; w_valid = 1'b1; w_data = 64'h77; w_strb = 8'hFF;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    ar_valid = 1'b1; ar_addr = 8'h08;
    tick();
    ar_valid = 1'b0;
    wait_r(nr + 1);
    chk("collision_old", obs_r[nr].d, 64'h11);
    rd(8'h08, d, r);
    chk("collision_reread", d, 64'h77);

    // Back-to-back reads.
    nr = obs_r.size();
    ar_valid = 1'b1; ar_addr = 8'h00; tick();
    ar_addr = 8'h08; tick();
    ar_addr = 8'h10; tick();
    ar_valid = 1'b0;
    wait_r(nr + 3);
    chk("stream_d0", obs_r[nr].d, 64'hA5A5);
    chk("stream_d1", obs_r[nr+1].d, 64'h77);
    chk("stream_d2", obs_r[nr+2].d, 64'h1122334455667788);
    chk("stream_resp", {obs_r[nr].r, obs_r[nr+1].r, obs_r[nr+2].r}, 6'b0);
    chk("stream_gap1", obs_r[nr+1].c - obs_r[nr].c, 1);
    chk("stream_gap2", obs_r[nr+2].c - obs_r[nr+1].c, 1);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nastilite_regfile.md
# nastilite_regfile

Parametrised NASTILite slave register file for controller configuration and status. It replaces the fixed-size configuration frontend and adds the following:
- Register count, address width and data width are set by parameters.
- Write address and write data are accepted independently, each through a one-deep buffer.
- Registers can be marked read-only and then return live status inputs.
- Out-of-range accesses return SLVERR.
- Each register has a per-register write strobe.

It sits between the configuration NASTILite port and the memory-controller core, which consumes `cfg_regs`.

## Interface

- `ADDR_WIDTH`, 8: byte-address width.
- `DATA_WIDTH`, 64: register and bus width; must be 32 or 64. `LSB` = log2(`DATA_WIDTH`/8).
- `NUM_REGS`, 8: number of registers, 1..2^(`ADDR_WIDTH`-`LSB`).
- `RO_MASK`, 0: `NUM_REGS` bits; bit k=1 makes register k read-only.
- `RESET_VALUE`, 0: `NUM_REGS`*`DATA_WIDTH` bits; register k resets to slice k.
- `s_nastilite_clk` in 1: sole clock.
- `s_nastilite_areset` in 1: reset, asynchronous, active-high.
- `s_nastilite_aw_valid` in 1, `s_nastilite_aw_ready` out 1, `s_nastilite_aw_addr` in `ADDR_WIDTH`: write address channel.
- `s_nastilite_w_valid` in 1, `s_nastilite_w_ready` out 1, `s_nastilite_w_data` in `DATA_WIDTH`, `s_nastilite_w_strb` in `DATA_WIDTH`/8: write data channel.
- `s_nastilite_b_valid` out 1, `s_nastilite_b_ready` in 1, `s_nastilite_b_resp` out 2: write response channel.
- `s_nastilite_ar_valid` in 1, `s_nastilite_ar_ready` out 1, `s_nastilite_ar_addr` in `ADDR_WIDTH`: read address channel.
- `s_nastilite_r_valid` out 1, `s_nastilite_r_ready` in 1, `s_nastilite_r_data` out `DATA_WIDTH`, `s_nastilite_r_resp` out 2: read data channel.
- `status_in` in `NUM_REGS`*`DATA_WIDTH`: live values returned for read-only registers.
- `cfg_regs` out `NUM_REGS`*`DATA_WIDTH`: current register contents, slice k = register k.
- `wr_pulse` out `NUM_REGS`: one-cycle strobe, bit k high after a committed write to register k.

## Operation

- **Address decode:** index = `addr[ADDR_WIDTH-1:LSB]`. Low `LSB` bits are ignored. An index ≥ `NUM_REGS` is out of range.
- **AW buffer:** one entry (address plus full flag). `aw_ready` = ~`aw_full`. The entry is captured on `aw_valid`&`aw_ready`.
- **W buffer:** one entry (data, strobe and full flag). `w_ready` = ~`w_full`. AW and W may arrive in any order and in any cycles.
- **Commit:** fires on the edge where `aw_full`&`w_full`&(~`b_valid` | `b_ready`). On that edge:
  - both buffers are cleared and `b_valid` is set to 1;
  - in range and writable: each byte lane i with `w_strb[i]`=1 is written, all `DATA_WIDTH`/8 lanes included. `b_resp`=00 and `wr_pulse[k]`=1 for the next cycle.
  - in range and read-only: no write, `b_resp`=00, no pulse.
  - out of range: no write, `b_resp`=10 (SLVERR), no pulse.
- **B channel:** `b_valid` holds until `b_ready`. It clears on `b_ready` unless a new commit fires on the same edge.
- **Read:** `ar_ready` = ~`r_valid` | `r_ready`. On `ar_valid`&`ar_ready`, on the same edge:
  - `r_valid` is set to 1;
  - `r_data` loads `cfg_regs[k]` (writable), `status_in[k]` (read-only) or 0 (out of range);
  - `r_resp` loads 00, 00 or 10 respectively.
- `r_valid` and `r_data` hold until `r_ready`.
- **Read/write collision:** a read and a commit to the same register on the same edge return the pre-write value.
- Read and write paths are independent; neither stalls the other.

## Timing

- **While reset is high, all outputs are held low:**
  - all ready signals;
  - `b_valid`, `b_resp`, `r_valid`, `r_resp` and `r_data`;
  - `wr_pulse`.
- **Reset effect on state:**
  - buffers are empty;
  - `cfg_regs` = `RESET_VALUE`;
  - readies rise combinationally once reset deasserts.
- **Reset mid-transaction:** buffered AW/W entries and any pending B/R beats are discarded. No response is ever issued for them.
- **Write latency:** AW and W both handshaken on edge N (both valid in the cycle before, `b_valid`=0) gives:
  - commit, `b_valid`=1 and updated `cfg_regs` visible after edge N+1;
  - `wr_pulse` high during cycle N+1..N+2.
- **Write throughput:** one write per 2 cycles.
- **Read latency:** `r_valid` rises after the handshake edge, one cycle. With `r_ready` held high, reads sustain one per cycle.
- **Backpressure:** with `b_valid`=1 and `b_ready`=0, at most one further AW and one W are buffered. Their readies then stay low until the commit.
- No combinational path from any valid to any ready. Ready depends only on state and on `r_ready` (AR path).

## Test plan

- **Reset:** assert `s_nastilite_areset` mid-write with `RESET_VALUE` slice 2 = 0x5A. Required: all valids 0 immediately and `cfg_regs[2]`=0x5A; no B beat after release.
- **AW/W order:** defaults. AW addr 0x10 in cycle 0, W data 0x1122334455667788 with strb 0xFF in cycle 3. Required: `b_resp`=00, `cfg_regs[2]`=0x1122334455667788, `wr_pulse`=0x04 for one cycle.
- **Partial strobe:** register 1 = 0. Write 0xFFFFFFFFFFFFFFFF with strb 0x81. Required: register 1 = 0xFF000000000000FF, including the top lane.
- **Out of range and read-only:** `NUM_REGS`=4, `RO_MASK`=0b1000.
  - Write addr 0x40: `b_resp`=10, no register changes.
  - Write addr 0x18: `b_resp`=00, register 3 unchanged.
  - Read 0x18 with `status_in[3]`=0xABCD: `r_data`=0xABCD.
- **Backpressure and collision:**
  - Hold `b_ready`=0 across two writes. Required: second write buffered, `aw_ready`=0, single B until `b_ready` rises, then second B.
  - Read addr 0x08 on the same edge as a commit of 0x77 to 0x08 over old value 0x11. Required: `r_data`=0x11, then a re-read returns 0x77.
- **Read streaming:** AR to 0x00, 0x08, 0x10 on consecutive cycles with `r_ready`=1. Required: three R beats on consecutive cycles, in order, `r_resp`=00.
